// File: rtl/pip_pkg.sv
// -----------------------------------------------------------------------------
// pip_pkg
//   Shared types and constants for the point-in-polygon vertex load path.
//   - state_t    : sender FSM states (IDLE -> SEND -> WAIT_DONE -> IDLE)
//   - ERR_*      : err_code values reported by pip_vertex_sender
//   - DEF_*      : default coordinate width, polygon size and handshake timeout
// -----------------------------------------------------------------------------
package pip_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_POINTS  = 5;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE           = 2'd0;
    localparam logic [1:0] ERR_START_NOT_FULL = 2'd1;
    localparam logic [1:0] ERR_WR_REJECT      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT        = 2'd3;

endpackage

// File: rtl/pip_vertex_buffer.sv
// -----------------------------------------------------------------------------
// pip_vertex_buffer
//   POINTS-deep register array holding packed vertices {x, y}.
//   One write port and one registered read port. The read register is zeroed
//   whenever rd_en is low, so the sender's x_in/y_in are 0 outside a burst and
//   drop to 0 immediately on an asynchronous reset.
// Ports
//   clk      in   rising-edge clock
//   rstN     in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write slot
//   wr_data  in   packed vertex {x, y}
//   rd_en    in   load read register from rd_addr (else clear it)
//   rd_addr  in   read slot
//   rd_data  out  registered read data {x, y}
// -----------------------------------------------------------------------------
module pip_vertex_buffer #(
    parameter int WIDTH  = pip_pkg::DEF_WIDTH,
    parameter int POINTS = pip_pkg::DEF_POINTS,
    parameter int CW     = $clog2(POINTS + 1)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_addr,
    output logic [2*WIDTH-1:0]   rd_data
);

    logic [2*WIDTH-1:0] mem [POINTS];

    // Storage carries no reset: contents are meaningless until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/pip_vertex_sender.sv
// -----------------------------------------------------------------------------
// pip_vertex_sender
//   Source side of the point-in-polygon vertex load interface. Collects POINTS
//   vertices from a host write port, then on start streams them one per cycle
//   on x_in/y_in with load high and waits (bounded) for load_done.
// Ports
//   clk, rstN            clock, asynchronous active-low reset
//   wr_en, wr_x, wr_y    host vertex write (accepted in IDLE while not full)
//   clear                empty the buffer and clear err_code (IDLE only)
//   start                begin burst (accepted in IDLE with a full buffer)
//   wr_full, count       buffer fill status
//   x_in, y_in, load     vertex stream to the datapath (0 when load low)
//   load_done            datapath has captured all vertices
//   busy                 FSM not idle
//   done, err            one-cycle result pulses
//   err_code             last error cause, held until next error or clear
//   dbg_state            current FSM state (pip_pkg::state_t encoding)
//
// Stream handshake: load is a valid-only strobe. There is no ready; the
// datapath must capture x_in/y_in on every cycle load is high, and the burst
// is exactly POINTS back-to-back beats. Completion is acknowledged separately
// by a load_done level sampled only while waiting for it.
// -----------------------------------------------------------------------------
module pip_vertex_sender
    import pip_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int POINTS  = DEF_POINTS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_x,
    input  logic [WIDTH-1:0]              wr_y,
    input  logic                          clear,
    input  logic                          start,
    output logic                          wr_full,
    output logic [$clog2(POINTS+1)-1:0]   count,
    output logic [WIDTH-1:0]              x_in,
    output logic [WIDTH-1:0]              y_in,
    output logic                          load,
    input  logic                          load_done,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [1:0]                    dbg_state
);

    localparam int CW = $clog2(POINTS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [TW-1:0] tmr_t;

    localparam cnt_t CNT_LAST = cnt_t'(POINTS - 1);
    localparam cnt_t CNT_FULL = cnt_t'(POINTS);
    localparam tmr_t TMR_LAST = tmr_t'(TIMEOUT - 1);

    state_t             state;
    cnt_t               rd_ptr;
    cnt_t               count_q;
    tmr_t               timer;

    logic               idle;
    logic               full;
    logic               start_ok;
    logic               start_bad;
    logic               wr_ok;
    logic               wr_rej;
    logic               rd_en;
    cnt_t               rd_addr;
    logic [2*WIDTH-1:0] rd_data;

    assign idle = (state == ST_IDLE);
    assign full = (count_q == CNT_FULL);

    // clear dominates everything else in IDLE. start is judged on the
    // pre-write count; a full buffer means any same-cycle write is rejected.
    assign start_ok  = idle && !clear && start &&  full;
    assign start_bad = idle && !clear && start && !full;
    assign wr_ok     = idle && !clear && wr_en && !full;
    assign wr_rej    = wr_en && !wr_ok && !(idle && clear);

    // Read address is the beat that will be on x_in/y_in next cycle, so the
    // registered read port lines data up with the registered load bit.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (start_ok) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (state == ST_SEND && rd_ptr != CNT_LAST) begin
            rd_en   = 1'b1;
            rd_addr = rd_ptr + cnt_t'(1);
        end
    end

    pip_vertex_buffer #(
        .WIDTH  (WIDTH),
        .POINTS (POINTS),
        .CW     (CW)
    ) u_buf (
        .clk     (clk),
        .rstN    (rstN),
        .wr_en   (wr_ok),
        .wr_addr (count_q),
        .wr_data ({wr_x, wr_y}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // rd_ptr always names the beat currently presented on x_in/y_in.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            count_q  <= '0;
            timer    <= '0;
            load     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            load <= rd_en;
            done <= 1'b0;
            err  <= 1'b0;

            if (wr_rej) begin
                err      <= 1'b1;
                err_code <= ERR_WR_REJECT;
            end

            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        count_q  <= '0;
                        err_code <= ERR_NONE;
                    end else begin
                        if (wr_ok) begin
                            count_q <= count_q + cnt_t'(1);
                        end
                        if (start_ok) begin
                            state  <= ST_SEND;
                            rd_ptr <= '0;
                        end else if (start_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_START_NOT_FULL;
                        end
                    end
                end

                ST_SEND: begin
                    if (rd_ptr == CNT_LAST) begin
                        state <= ST_WAIT_DONE;
                        timer <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + cnt_t'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    // load_done takes precedence over a coincident timeout.
                    if (load_done) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (timer == TMR_LAST) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + tmr_t'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_full   = full;
    assign count     = count_q;
    assign busy      = !idle;
    assign x_in      = rd_data[2*WIDTH-1:WIDTH];
    assign y_in      = rd_data[WIDTH-1:0];
    assign dbg_state = state;

endmodule

// File: tb/tb_pip_vertex_sender.sv
// -----------------------------------------------------------------------------
// tb_pip_vertex_sender
//   Self-checking bench for pip_vertex_sender. The model is a queue holding the
//   polygon as written (exp_q) plus the expected err_code; each scenario task
//   derives expected outputs from the interface rules and cycle latencies.
// -----------------------------------------------------------------------------
module tb_pip_vertex_sender;
    import pip_pkg::*;

    localparam int W       = 16;
    localparam int POINTS  = 5;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(POINTS + 1);

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rstN;
    logic          wr_en, clear, start, load_done;
    logic [W-1:0]  wr_x, wr_y;
    logic          wr_full, load, busy, done, err;
    logic [CW-1:0] count;
    logic [W-1:0]  x_in, y_in;
    logic [1:0]    err_code, dbg_state;

    always #5 clk = ~clk;

    pip_vertex_sender #(.WIDTH(W), .POINTS(POINTS), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .clear     (clear),
        .start     (start),
        .wr_full   (wr_full),
        .count     (count),
        .x_in      (x_in),
        .y_in      (y_in),
        .load      (load),
        .load_done (load_done),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    logic [1:0]     m_code;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge: inputs set here are sampled
    // at the following edge, outputs read here reflect the edge just passed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
        m_code = ERR_NONE;
        check("clear_count", count, 0);
        check("clear_code", err_code, m_code);
        check("clear_full", wr_full, 0);
    endtask

    task automatic write_vtx(input logic [W-1:0] x, input logic [W-1:0] y);
        bit accept;
        accept = (exp_q.size() < POINTS);
        wr_en = 1'b1; wr_x = x; wr_y = y;
        step();
        wr_en = 1'b0;
        if (accept) begin
            exp_q.push_back({x, y});
            check("wr_err_none", err, 0);
        end else begin
            m_code = ERR_WR_REJECT;
            check("wr_reject_err", err, 1);
        end
        check("wr_count", count, exp_q.size());
        check("wr_code", err_code, m_code);
        check("wr_full", wr_full, exp_q.size() == POINTS);
    endtask

    task automatic write_random_polygon();
        for (int i = 0; i < POINTS; i++)
            write_vtx(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
    endtask

    // Full burst with a full buffer. ld_delay: cycles after load falls before
    // load_done is raised (<0 = never). wr_beat: beat index at which a write is
    // attempted (<0 = none). sw: raise wr_en together with start.
    task automatic run_burst(input int ld_delay, input int wr_beat, input bit sw);
        logic [2*W-1:0] v;
        bit             ended;
        start = 1'b1;
        wr_en = sw;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        if (sw) begin
            m_code = ERR_WR_REJECT;
            check("start_wr_err", err, 1);
            check("start_wr_code", err_code, m_code);
        end else begin
            check("start_no_err", err, 0);
        end
        for (int i = 0; i < POINTS; i++) begin
            v = exp_q[i];
            check("beat_load", load, 1);
            check("beat_busy", busy, 1);
            check("beat_x", x_in, v[2*W-1:W]);
            check("beat_y", y_in, v[W-1:0]);
            wr_en = (i == wr_beat);
            step();
            if (i == wr_beat) begin
                wr_en = 1'b0;
                m_code = ERR_WR_REJECT;
                check("send_wr_err", err, 1);
                check("send_wr_code", err_code, m_code);
                check("send_wr_count", count, POINTS);
            end
        end
        check("load_fall", load, 0);
        check("load_fall_x", x_in, 0);
        check("load_fall_y", y_in, 0);
        check("wait_busy", busy, 1);
        ended = 1'b0;
        for (int k = 0; k <= TIMEOUT + 1 && !ended; k++) begin
            load_done = (k == ld_delay);
            step();
            load_done = 1'b0;
            if (ld_delay >= 0 && k == ld_delay) begin
                ended = 1'b1;
                check("done_pulse", done, 1);
                check("done_no_err", err, 0);
                check("done_idle", busy, 0);
            end else if (ld_delay < 0 && k == TIMEOUT - 1) begin
                ended = 1'b1;
                m_code = ERR_TIMEOUT;
                check("timeout_err", err, 1);
                check("timeout_no_done", done, 0);
                check("timeout_idle", busy, 0);
            end else begin
                check("wait_quiet_done", done, 0);
                check("wait_quiet_err", err, 0);
                check("wait_busy_hold", busy, 1);
            end
        end
        check("burst_ended", ended, 1);
        check("burst_code", err_code, m_code);
        check("burst_count_kept", count, POINTS);
        step();
        check("pulse_1cycle_done", done, 0);
        check("pulse_1cycle_err", err, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] sq_x [5];
        logic [W-1:0] sq_y [5];
        sq_x = '{16'd0, 16'd10, 16'd10, 16'd5, 16'd0};
        sq_y = '{16'd0, 16'd0,  16'd10, 16'd15, 16'd10};

        rstN = 1'b0; wr_en = 1'b0; clear = 1'b0; start = 1'b0; load_done = 1'b0;
        wr_x = '0; wr_y = '0;
        m_code = ERR_NONE;
        repeat (3) step();
        check("rst_load", load, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_x", x_in, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_full", wr_full, 0);
        rstN = 1'b1;
        step();

        // 1: reference polygon, load_done right after the burst
        for (int i = 0; i < POINTS; i++) write_vtx(sq_x[i], sq_y[i]);
        run_burst(0, -1, 1'b0);

        // 2: partial buffer start, and start+write with a partial buffer
        do_clear();
        for (int i = 0; i < 3; i++) write_vtx(W'($urandom_range(0, 65535)), W'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        m_code = ERR_START_NOT_FULL;
        check("short_start_err", err, 1);
        check("short_start_code", err_code, m_code);
        for (int i = 0; i < 4; i++) begin
            check("short_no_load", load, 0);
            check("short_idle", busy, 0);
            step();
        end
        start = 1'b1; wr_en = 1'b1; wr_x = 16'h1234; wr_y = 16'h5678;
        step();
        start = 1'b0; wr_en = 1'b0;
        exp_q.push_back({16'h1234, 16'h5678});
        check("start_wr_short_err", err, 1);
        check("start_wr_short_code", err_code, m_code);
        check("start_wr_short_count", count, exp_q.size());
        check("start_wr_short_idle", busy, 0);

        // 3: overfill, then a write during SEND
        write_vtx(16'hAAAA, 16'h5555);
        write_vtx(16'hBEEF, 16'hCAFE);
        run_burst(3, 2, 1'b0);

        // 4: timeout, then resend without rewriting
        run_burst(-1, -1, 1'b0);
        run_burst($urandom_range(0, TIMEOUT - 1), -1, 1'b0);

        // 6: clear with a same-cycle write; load_done coincident with timeout
        clear = 1'b1; wr_en = 1'b1; wr_x = 16'h0F0F; wr_y = 16'hF0F0;
        step();
        clear = 1'b0; wr_en = 1'b0;
        exp_q.delete();
        m_code = ERR_NONE;
        check("clear_wr_count", count, 0);
        check("clear_wr_err", err, 0);
        check("clear_wr_code", err_code, m_code);
        write_random_polygon();
        run_burst(TIMEOUT - 1, -1, 1'b0);

        // randomized bursts
        for (int it = 0; it < 6; it++) begin
            int wb;
            do_clear();
            write_random_polygon();
            wb = $urandom_range(0, 2 * POINTS);
            run_burst($urandom_range(0, TIMEOUT - 1), (wb < POINTS) ? wb : -1,
                      1'($urandom_range(0, 1)));
        end

        // 5: reset on the third load beat
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_load", load, 1);
        rstN = 1'b0;
        #1;
        check("mid_rst_load", load, 0);
        check("mid_rst_x", x_in, 0);
        check("mid_rst_y", y_in, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        m_code = ERR_NONE;
        step();
        rstN = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        m_code = ERR_START_NOT_FULL;
        check("post_rst_start_err", err, 1);
        check("post_rst_start_code", err_code, m_code);
        step();
        check("post_rst_no_load", load, 0);
        check("post_rst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
